rrip_victim_select: RTL and testbench
=====================================

Name: rrip_victim_select

Overview:
- Per-set RRIP replacement-state array and victim selector.
- Sits directly downstream of the SHiP insertion predictor. It consumes SHiP's insertion RRPV and produces the evict_way that SHiP and the cache data/tag arrays use on a miss.
- Hits promote a way to RRPV 0.
- Misses search the set for a distant-RRPV way. If none is found, the block ages the whole set one step per cycle until one appears, then installs the predicted RRPV in the chosen way.

Parameters:
- ASSOCIATIVITY, 4: number of ways per set.
- SET_SIZE, 2: width of a way index (log2 ASSOCIATIVITY).
- INDEX_WIDTH, 4: width of the set index.
- DEPTH, 16: number of sets (2**INDEX_WIDTH).
- M, 2: RRPV width. DISTANT = 2**M-1.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  1  request strobe.
- req_hit  input  1  request is a cache hit.
- req_miss  input  1  request is a cache miss.
- halt  input  1  pipeline stall. Freezes all state.
- req_index  input  INDEX_WIDTH  set index of the request.
- req_hit_way  input  SET_SIZE  way that hit. Valid when req_hit=1.
- ins_rrpv  input  M  insertion RRPV from SHiP. Sampled when a miss is accepted.
- req_ready  output  1  block is idle and can accept a request.
- victim_valid  output  1  one-cycle pulse: victim_way is valid and the insertion is done.
- victim_way  output  SET_SIZE  selected victim way. Holds its value until the next victim.
- busy  output  1  a miss search is in progress.

Behaviour:
- State: rrpv[ASSOCIATIVITY][DEPTH], M bits each. FSM is IDLE or SEARCH.
- Latched on miss acceptance: index and ins_rrpv.
- Reset (rst=1 at a clock edge):
  - All rrpv = DISTANT; FSM = IDLE.
  - victim_valid=0, victim_way=0, busy=0.
  - req_ready = (state==IDLE), so it reads 1 out of reset.
  - Reset during SEARCH aborts the search: no victim_valid pulse, and the latched request is discarded.
- Acceptance: a request is accepted only when req_valid && req_ready && !halt.
- Hit in IDLE:
  - rrpv[req_hit_way][req_index] <= 0 on that edge. FSM stays IDLE.
  - No victim_valid pulse.
- Miss in IDLE: latch index and ins_rrpv, then go to SEARCH.
- Hit and miss both asserted: treated as a hit; the miss is ignored.
- req_valid with neither hit nor miss: no effect.
- SEARCH cycle, when halt=0:
  - If any way in the latched set has rrpv==DISTANT:
    - Pick the lowest-numbered such way.
    - victim_way <= way; victim_valid <= 1 for exactly one cycle.
    - rrpv[way][set] <= latched ins_rrpv.
    - Go to IDLE.
  - Otherwise, increment every way in the set by 1 (no overflow is possible, since no way is at max) and stay in SEARCH.
- Latency:
  - Miss accepted at edge 0; victim_valid is high in cycle 1+k.
  - k = DISTANT - max(rrpv in set). Worst case k = DISTANT.
  - req_ready is low from cycle 1 through the victim_valid cycle. It returns high the cycle after victim_valid.
- Halt:
  - In SEARCH, halt=1 freezes the block: no aging, no victim, no pulse.
  - victim_valid is forced low while halted; the pulse issues on the first unhalted SEARCH cycle.
- busy = (state==SEARCH). req_ready = !busy.
- Other sets are untouched during a search. Hit-during-search cannot happen because req_ready is 0.
- Array updates are registered. A read of the same set in the cycle after a write sees the new value.

Test Plan:
- Scenario 1: reset, then miss set 5 with ins_rrpv=2.
  - victim_valid in cycle 1 with victim_way=0.
  - rrpv[0][5]=2; the other ways of set 5 stay at 3.
- Scenario 2: four consecutive misses to set 3, each with ins_rrpv=2.
  - Victims are ways 0,1,2,3, each at 1-cycle latency.
  - A fifth miss ages once, giving all ways = 3, then victim way 0 in cycle 2. rrpv[0][3]=2.
- Scenario 3: fill set 3 with ins_rrpv=2, then hit way 1, giving {2,0,2,2}.
  - Next miss (ins_rrpv=3) gives {3,1,3,3} after one age.
  - victim_way=0 in cycle 2; final set state {3,1,3,3}.
- Scenario 4: fill set 7 with ins_rrpv=0, then miss.
  - Three aging cycles; victim_valid in cycle 4 with victim_way=0.
  - req_ready low for cycles 1-4.
- Scenario 5: set 7 as in scenario 4, with halt=1 for 5 cycles starting in cycle 2.
  - No aging while halted; victim_valid delayed to cycle 9.
  - The same request asserted with req_hit and req_miss both high acts as a hit: rrpv[hit_way]=0 and no search starts.
- Scenario 6: assert rst in cycle 2 of a worst-case search.
  - No victim_valid pulse; req_ready=1 the next cycle.
  - All rrpv=3, and the next miss returns victim way 0 in cycle 1.

Source files
------------

// File: rtl/rrip_victim_select_if.sv
// Request/victim handshake between the SHiP predictor side and the RRIP victim selector.
// The master drives requests; the slave (the selector) returns readiness and the victim.
interface rrip_victim_select_if #(
    parameter int INDEX_WIDTH = 4,
    parameter int SET_SIZE    = 2,
    parameter int M           = 2
);
    logic                   req_valid;
    logic                   req_hit;
    logic                   req_miss;
    logic                   halt;
    logic [INDEX_WIDTH-1:0] req_index;
    logic [SET_SIZE-1:0]    req_hit_way;
    logic [M-1:0]           ins_rrpv;
    logic                   req_ready;
    logic                   victim_valid;
    logic [SET_SIZE-1:0]    victim_way;
    logic                   busy;

    modport master (
        output req_valid, req_hit, req_miss, halt, req_index, req_hit_way, ins_rrpv,
        input  req_ready, victim_valid, victim_way, busy
    );

    modport slave (
        input  req_valid, req_hit, req_miss, halt, req_index, req_hit_way, ins_rrpv,
        output req_ready, victim_valid, victim_way, busy
    );
endinterface

// File: rtl/rrip_victim_select.sv
// Per-set RRIP replacement state with victim search: hits promote to RRPV 0, misses age the
// set until a distant way exists, then install the predicted RRPV in the lowest such way.
module rrip_victim_select #(
    parameter int ASSOCIATIVITY = 4,
    parameter int SET_SIZE      = 2,
    parameter int INDEX_WIDTH   = 4,
    parameter int DEPTH         = 16,
    parameter int M             = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    rrip_victim_select_if.slave  bus
);
    localparam logic [M-1:0] DISTANT = '1;

    typedef enum logic {IDLE, SEARCH} state_t;

    state_t                 state_q, state_d;
    logic [M-1:0]           rrpv_q [ASSOCIATIVITY][DEPTH];
    logic [M-1:0]           rrpv_d [ASSOCIATIVITY][DEPTH];
    logic [INDEX_WIDTH-1:0] idx_q, idx_d;
    logic [M-1:0]           ins_q, ins_d;
    logic [SET_SIZE-1:0]    victim_way_q, victim_way_d;
    logic                   found;
    logic [SET_SIZE-1:0]    found_way;
    logic                   accept;
    logic                   fire;

    // Saturating one-step age; the search only ages when no way is distant.
    function automatic logic [M-1:0] age_rrpv(input logic [M-1:0] v);
        return (v == DISTANT) ? v : v + M'(1);
    endfunction

    // Descending scan so the lowest-numbered distant way wins.
    always_comb begin
        found     = 1'b0;
        found_way = '0;
        for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
            if (rrpv_q[w][idx_q] == DISTANT) begin
                found     = 1'b1;
                found_way = SET_SIZE'(w);
            end
        end
    end

    always_comb begin
        accept       = bus.req_valid && (state_q == IDLE) && !bus.halt;
        fire         = (state_q == SEARCH) && !bus.halt && found;
        state_d      = state_q;
        idx_d        = idx_q;
        ins_d        = ins_q;
        victim_way_d = victim_way_q;
        rrpv_d       = rrpv_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.req_hit) begin
                        rrpv_d[bus.req_hit_way][bus.req_index] = '0;
                    end else if (bus.req_miss) begin
                        idx_d   = bus.req_index;
                        ins_d   = bus.ins_rrpv;
                        state_d = SEARCH;
                    end
                end
            end
            SEARCH: begin
                if (fire) begin
                    victim_way_d             = found_way;
                    rrpv_d[found_way][idx_q] = ins_q;
                    state_d                  = IDLE;
                end else if (!bus.halt) begin
                    for (int w = 0; w < ASSOCIATIVITY; w++) begin
                        rrpv_d[w][idx_q] = age_rrpv(rrpv_q[w][idx_q]);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            victim_way_q <= '0;
            for (int w = 0; w < ASSOCIATIVITY; w++) begin
                for (int s = 0; s < DEPTH; s++) begin
                    rrpv_q[w][s] <= DISTANT;
                end
            end
        end else begin
            state_q      <= state_d;
            victim_way_q <= victim_way_d;
            rrpv_q       <= rrpv_d;
        end
        // Latched request carries no meaning outside SEARCH, so it is left unreset.
        idx_q <= idx_d;
        ins_q <= ins_d;
    end

    // The pulse is presented in the SEARCH cycle that finds the victim; a reset edge aborts it.
    assign bus.busy         = (state_q == SEARCH);
    assign bus.req_ready    = (state_q == IDLE);
    assign bus.victim_valid = fire && !rst;
    assign bus.victim_way   = fire ? found_way : victim_way_q;
endmodule

// File: tb/tb_rrip_victim_select.sv
// Directed bench for rrip_victim_select with a transaction-level replacement model.
module tb_rrip_victim_select;
  localparam int A = 4, SS = 2, IW = 4, D = 16, M = 2, DIST = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rrip_victim_select_if #(.INDEX_WIDTH(IW), .SET_SIZE(SS), .M(M)) bus ();

  rrip_victim_select #(
    .ASSOCIATIVITY(A), .SET_SIZE(SS), .INDEX_WIDTH(IW), .DEPTH(D), .M(M)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Model: a miss resolves as a whole transaction. The victim is the lowest way holding the
  // set's maximum RRPV, found after (DIST - max) unhalted aging cycles.
  int m_rrpv[A][D];
  int m_search = 0, m_valid = 0, m_rem = 0, m_k = 0;
  int m_idx = 0, m_ins = 0, m_way = 0, m_last = 0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      for (int w = 0; w < A; w++)
        for (int s = 0; s < D; s++) m_rrpv[w][s] = DIST;
      m_search = 0;
      m_last   = 0;
      m_valid  = 1;
    end else if (m_valid != 0) begin
      if (m_search != 0) begin
        if (!bus.halt) begin
          if (m_rem == 0) begin
            for (int w = 0; w < A; w++) m_rrpv[w][m_idx] += m_k;
            m_rrpv[m_way][m_idx] = m_ins;
            m_last   = m_way;
            m_search = 0;
          end else begin
            m_rem--;
          end
        end
      end else if (bus.req_valid && !bus.halt) begin
        if (bus.req_hit) begin
          m_rrpv[int'(bus.req_hit_way)][int'(bus.req_index)] = 0;
        end else if (bus.req_miss) begin
          int mx;
          m_idx = int'(bus.req_index);
          m_ins = int'(bus.ins_rrpv);
          mx = 0;
          for (int w = 0; w < A; w++) if (m_rrpv[w][m_idx] > mx) mx = m_rrpv[w][m_idx];
          m_way = -1;
          for (int w = A - 1; w >= 0; w--) if (m_rrpv[w][m_idx] == mx) m_way = w;
          m_k      = DIST - mx;
          m_rem    = m_k;
          m_search = 1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge clk);
    if (m_valid != 0) begin
      int exp_vv, exp_way;
      exp_vv  = (m_search != 0 && !bus.halt && !rst && m_rem == 0) ? 1 : 0;
      exp_way = (exp_vv != 0) ? m_way : m_last;
      chk("cyc victim_valid", int'(bus.victim_valid), exp_vv);
      chk("cyc victim_way", int'(bus.victim_way), exp_way);
      chk("cyc busy", int'(bus.busy), m_search);
      chk("cyc req_ready", int'(bus.req_ready), 1 - m_search);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit h, input bit m, input int idx, input int hw, input int ins);
    bus.req_valid   = 1'b1;
    bus.req_hit     = h;
    bus.req_miss    = m;
    bus.req_index   = IW'(idx);
    bus.req_hit_way = SS'(hw);
    bus.ins_rrpv    = M'(ins);
    tick();
    bus.req_valid = 1'b0;
    bus.req_hit   = 1'b0;
    bus.req_miss  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_set(input string name, input int s, input int e0, input int e1,
                         input int e2, input int e3);
    int e[A];
    e = '{e0, e1, e2, e3};
    for (int w = 0; w < A; w++) begin
      chk({name, " dut rrpv"}, int'(dut.rrpv_q[w][s]), e[w]);
      chk({name, " model rrpv"}, m_rrpv[w][s], e[w]);
    end
  endtask

  // Issue a miss and follow it cycle by cycle. hs/hl: halt window; rst_at: reset cycle (0 = none).
  // exp_cyc = -1 means no pulse may appear.
  task automatic miss_wait(input string name, input int idx, input int ins, input int hs,
                           input int hl, input int rst_at, input int exp_cyc, input int exp_way);
    int got;
    got = -1;
    issue(1'b0, 1'b1, idx, 0, ins);
    for (int c = 1; c <= 12 && got < 0; c++) begin
      bus.halt = (c >= hs && c < hs + hl);
      rst      = (c == rst_at);
      @(negedge clk);
      if (rst_at == 0 || c <= rst_at) chk({name, " ready low"}, int'(bus.req_ready), 0);
      if (bus.victim_valid) begin
        got = c;
        chk({name, " way"}, int'(bus.victim_way), exp_way);
      end
      tick();
    end
    bus.halt = 1'b0;
    rst      = 1'b0;
    chk({name, " pulse cycle"}, got, exp_cyc);
    @(negedge clk);
    chk({name, " ready after"}, int'(bus.req_ready), 1);
    tick();
  endtask

  task automatic fill(input string name, input int idx, input int ins);
    for (int w = 0; w < A; w++) miss_wait(name, idx, ins, 0, 0, 0, 1, w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time 200000 reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_hit = 1'b0; bus.req_miss = 1'b0; bus.halt = 1'b0;
    bus.req_index = '0; bus.req_hit_way = '0; bus.ins_rrpv = '0;
    do_reset();

    // Reset state.
    @(negedge clk);
    chk("reset req_ready", int'(bus.req_ready), 1);
    chk("reset victim_valid", int'(bus.victim_valid), 0);
    chk("reset victim_way", int'(bus.victim_way), 0);
    chk("reset busy", int'(bus.busy), 0);
    tick();
    chk_set("reset set5", 5, 3, 3, 3, 3);

    // Scenario 1.
    miss_wait("s1", 5, 2, 0, 0, 0, 1, 0);
    chk_set("s1 set5", 5, 2, 3, 3, 3);

    // Request with neither hit nor miss, and a request blocked by halt: no effect.
    issue(1'b0, 1'b0, 5, 1, 0);
    @(negedge clk);
    chk("no-op busy", int'(bus.busy), 0);
    tick();
    bus.halt = 1'b1;
    issue(1'b0, 1'b1, 5, 0, 1);
    bus.halt = 1'b0;
    @(negedge clk);
    chk("halted req busy", int'(bus.busy), 0);
    tick();
    chk_set("no-op set5", 5, 2, 3, 3, 3);

    // Scenario 2.
    do_reset();
    fill("s2 fill", 3, 2);
    miss_wait("s2 fifth", 3, 2, 0, 0, 0, 2, 0);
    chk_set("s2 set3", 3, 2, 3, 3, 3);

    // Scenario 3.
    do_reset();
    fill("s3 fill", 3, 2);
    issue(1'b1, 1'b0, 3, 1, 0);
    chk_set("s3 after hit", 3, 2, 0, 2, 2);
    miss_wait("s3 miss", 3, 3, 0, 0, 0, 2, 0);
    chk_set("s3 set3", 3, 3, 1, 3, 3);

    // Scenario 4.
    do_reset();
    fill("s4 fill", 7, 0);
    miss_wait("s4 miss", 7, 1, 0, 0, 0, 4, 0);
    chk_set("s4 set7", 7, 1, 3, 3, 3);

    // Scenario 5: halted search, then hit+miss together behaves as a hit.
    do_reset();
    fill("s5 fill", 7, 0);
    miss_wait("s5 miss", 7, 1, 2, 5, 0, 9, 0);
    chk_set("s5 set7", 7, 1, 3, 3, 3);
    issue(1'b1, 1'b1, 7, 2, 0);
    @(negedge clk);
    chk("s5 hit+miss busy", int'(bus.busy), 0);
    tick();
    chk_set("s5 hit+miss set7", 7, 1, 3, 0, 3);

    // Scenario 6: reset mid-search.
    do_reset();
    fill("s6 fill", 7, 0);
    miss_wait("s6 aborted", 7, 2, 0, 0, 2, -1, 0);
    chk_set("s6 set7", 7, 3, 3, 3, 3);
    chk_set("s6 set0", 0, 3, 3, 3, 3);
    miss_wait("s6 next", 7, 2, 0, 0, 0, 1, 0);
    chk_set("s6 final set7", 7, 2, 3, 3, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
